// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the one-bit FSM state encoding and the iteration-counter width helper.
package seq_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Counter must hold 0..WIDTH; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider.
//   start, dividend, divisor : requester -> divider
//   busy, done, quotient, remainder : divider -> requester
//   div_zero : divider -> requester, only when DIV_ZERO_FLAG_EN is defined
// master = requester side, slave = divider side.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic             div_zero;
`endif

  modport master (
    output start, dividend, divisor,
`ifdef DIV_ZERO_FLAG_EN
    input  div_zero,
`endif
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef DIV_ZERO_FLAG_EN
    output div_zero,
`endif
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration (combinational).
//   r_i       : current partial remainder (always < divisor, or <= dividend for divisor 0)
//   msb_i     : next dividend bit shifted in
//   divisor_i : divisor
//   r_o       : next partial remainder
//   qbit_o    : quotient bit produced by this iteration
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_o,
  output logic             qbit_o
);

  // Shifted remainder is WIDTH+1 bits so the compare never overflows.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign shifted = {r_i, msb_i};
  assign ge      = (shifted >= {1'b0, divisor_i});
  // When ge holds the true difference is < divisor, so the low bits are exact.
  assign diff    = shifted[WIDTH-1:0] - divisor_i;
  assign r_o     = ge ? diff : shifted[WIDTH-1:0];
  assign qbit_o  = ge;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : seq_divider_if.slave (start/dividend/divisor in,
//                busy/done/quotient/remainder[/div_zero] out)
// Latency is WIDTH cycles from the accepting edge to done, independent of operands.
// Optional build macro: DIV_ZERO_FLAG_EN adds the registered div_zero flag.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int unsigned    CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_shift_q, q_shift_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
`ifdef DIV_ZERO_FLAG_EN
  logic             dz_q, dz_d;
`endif

  logic [WIDTH-1:0] step_r;
  logic             step_qbit;

  // q_shift holds the unconsumed dividend bits at the top and collects quotient
  // bits at the bottom, so its MSB is always the next dividend bit.
  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i       (r_q),
    .msb_i     (q_shift_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_shift_d = q_shift_q;
    dvs_d     = dvs_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
    dz_d      = dz_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          r_d       = '0;
          q_shift_d = bus.dividend;
          dvs_d     = bus.divisor;
        end
      end
      ST_RUN: begin
        r_d       = step_r;
        q_shift_d = {q_shift_q[WIDTH-2:0], step_qbit};
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          quot_d  = {q_shift_q[WIDTH-2:0], step_qbit};
          rem_d   = step_r;
`ifdef DIV_ZERO_FLAG_EN
          dz_d    = (dvs_q == '0);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_shift_q <= '0;
      dvs_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_shift_q <= q_shift_d;
      dvs_q     <= dvs_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
`ifdef DIV_ZERO_FLAG_EN
      dz_q      <= dz_d;
`endif
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
`ifdef DIV_ZERO_FLAG_EN
  assign bus.div_zero  = dz_q;
`endif

endmodule
